// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants and redirect priority levels for the fetch front end
package mips_pkg;
   localparam logic [5:0] ALU_OP = 6'd0;
   localparam logic [5:0] J_OP   = 6'd2;
   localparam logic [5:0] JAL_OP = 6'd3;
   localparam logic [5:0] BEQ_OP = 6'd4;
   localparam logic [5:0] BNE_OP = 6'd5;
   localparam logic [5:0] JR_F   = 6'd8;
   localparam logic [5:0] JALR_F = 6'd9;
   // Encoding order is the priority order; relational compares rely on it.
   typedef enum logic [2:0] {NONE, SEQ, IDJ, EXR, EXC} level_t;
endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: decodes the incoming redirect and arbitrates it against the pending one
module pc_redirect_sel import mips_pkg::*; #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic [XLEN-1:0] pc_plus4,
   input  logic            id_valid,
   input  logic [5:0]      id_op,
   input  logic [25:0]     id_jindex,
   input  logic            ex_valid,
   input  logic [5:0]      ex_op,
   input  logic [5:0]      ex_funct,
   input  logic [XLEN-1:0] ex_rs_val,
   input  logic            ex_br_taken,
   input  logic [XLEN-1:0] ex_br_target,
   input  logic            exc_req,
   input  level_t          pend_level,
   input  logic [XLEN-1:0] pend_target,
   output level_t          in_level,
   output logic [XLEN-1:0] in_target,
   output logic            use_in,
   output logic            jr_misalign,
   output level_t          eff_level,
   output logic [XLEN-1:0] eff_target
);
   logic jr, br, idj;
   always_comb begin
      jr          = ex_valid && ex_op == ALU_OP && (ex_funct == JR_F || ex_funct == JALR_F);
      br          = ex_valid && ex_br_taken;
      idj         = id_valid && (id_op == J_OP || id_op == JAL_OP);
      in_level    = exc_req ? EXC : (jr || br) ? EXR : idj ? IDJ : SEQ;
      in_target   = exc_req ? EXC_VECTOR :
                    jr      ? {ex_rs_val[XLEN-1:2], 2'b00} :
                    br      ? ex_br_target :
                    idj     ? {pc_plus4[XLEN-1:28], id_jindex, 2'b00} : pc_plus4;
      use_in      = in_level >= pend_level;
      jr_misalign = jr && !exc_req && |ex_rs_val[1:0];
      eff_level   = use_in ? in_level : pend_level;
      eff_target  = use_in ? in_target : pend_target;
   end
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: PC register with prioritised redirects, stall-time redirect latch and flush generation
module next_pc_unit import mips_pkg::*; #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             stall,
   input  logic             id_valid,
   input  logic [5:0]       id_op,
   input  logic [25:0]      id_jindex,
   input  logic             ex_valid,
   input  logic [5:0]       ex_op,
   input  logic [5:0]       ex_funct,
   input  logic [XLEN-1:0]  ex_rs_val,
   input  logic             ex_br_taken,
   input  logic [XLEN-1:0]  ex_br_target,
   input  logic             exc_req,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             flush_if,
   output logic             flush_id,
   output logic             pending,
   output logic             addr_err,
   output logic [CNT_W-1:0] redirect_cnt
);
   level_t pend_level, in_level, eff_level;
   logic [XLEN-1:0] pend_target, in_target, eff_target;
   logic use_in, jr_misalign;
   pc_redirect_sel #(.XLEN(XLEN), .EXC_VECTOR(EXC_VECTOR)) u_sel (
      .pc_plus4(pc_plus4), .id_valid(id_valid), .id_op(id_op), .id_jindex(id_jindex),
      .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct), .ex_rs_val(ex_rs_val),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .exc_req(exc_req),
      .pend_level(pend_level), .pend_target(pend_target), .in_level(in_level),
      .in_target(in_target), .use_in(use_in), .jr_misalign(jr_misalign),
      .eff_level(eff_level), .eff_target(eff_target)
   );
   always_comb begin
      pc_plus4 = pc + XLEN'(4);
      pending  = pend_level != NONE;
      flush_if = !stall && eff_level >= IDJ;
      flush_id = !stall && eff_level >= EXR;
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pc           <= RESET_VECTOR;
         pend_level   <= NONE;
         pend_target  <= '0;
         addr_err     <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         addr_err <= jr_misalign && use_in;
         if (stall) begin
            if (in_level != SEQ && use_in) begin
               pend_level  <= in_level;
               pend_target <= in_target;
            end
         end else begin
            pc         <= eff_target;
            pend_level <= NONE;
            if (eff_level != SEQ && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed checks of next_pc_unit priority, stall latching, flushes and counter
module tb_next_pc_unit;
   logic clock = 0, resetn = 0, resetn2 = 0, stall = 0;
   logic id_valid = 0, ex_valid = 0, ex_br_taken = 0, exc_req = 0;
   logic [5:0] id_op = 0, ex_op = 0, ex_funct = 0;
   logic [25:0] id_jindex = 0;
   logic [31:0] ex_rs_val = 0, ex_br_target = 0;
   logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
   logic flush_if, flush_id, pending, addr_err;
   logic flush_if2, flush_id2, pending2, addr_err2;
   logic [15:0] redirect_cnt;
   logic [1:0] redirect_cnt2;
   int total = 0, bad = 0;

   always #5 clock = ~clock;

   next_pc_unit dut (
      .clock(clock), .resetn(resetn), .stall(stall), .id_valid(id_valid), .id_op(id_op),
      .id_jindex(id_jindex), .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct),
      .ex_rs_val(ex_rs_val), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .exc_req(exc_req), .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if),
      .flush_id(flush_id), .pending(pending), .addr_err(addr_err), .redirect_cnt(redirect_cnt)
   );

   next_pc_unit #(.CNT_W(2), .RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
      .clock(clock), .resetn(resetn2), .stall(stall), .id_valid(id_valid), .id_op(id_op),
      .id_jindex(id_jindex), .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct),
      .ex_rs_val(ex_rs_val), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .exc_req(exc_req), .pc(pc2), .pc_plus4(pc_plus4_2), .flush_if(flush_if2),
      .flush_id(flush_id2), .pending(pending2), .addr_err(addr_err2), .redirect_cnt(redirect_cnt2)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      resetn = 0;
      tick();
      tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=%h", pc, 32'h0); end
      total++; if (redirect_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", redirect_cnt); end
      total++; if (pending !== 1'b0 || addr_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", pending, addr_err); end
      resetn = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", i, pc, 32'(4 * i)); end
      end
      total++; if (redirect_cnt !== 16'd0) begin bad++; $display("FAIL seq_cnt got=%0d want=0", redirect_cnt); end
   endtask

   task automatic test_idj;
      ex_valid = 1; ex_op = 6'd0; ex_funct = 6'd8; ex_rs_val = 32'h4000_0010;
      #1;
      total++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin bad++; $display("FAIL jr_flush got=%b%b want=11", flush_if, flush_id); end
      tick();
      ex_valid = 0;
      total++; if (pc !== 32'h4000_0010) begin bad++; $display("FAIL jr_pc got=%h want=%h", pc, 32'h4000_0010); end
      id_valid = 1; id_op = 6'd2; id_jindex = 26'h0000100;
      #1;
      total++; if (flush_if !== 1'b1 || flush_id !== 1'b0) begin bad++; $display("FAIL j_flush got=%b%b want=10", flush_if, flush_id); end
      tick();
      id_valid = 0;
      total++; if (pc !== 32'h4000_0400) begin bad++; $display("FAIL j_pc got=%h want=%h", pc, 32'h4000_0400); end
      total++; if (redirect_cnt !== 16'd2) begin bad++; $display("FAIL j_cnt got=%0d want=2", redirect_cnt); end
   endtask

   task automatic test_priority;
      id_valid = 1; id_op = 6'd3; id_jindex = 26'h0000100;
      ex_valid = 1; ex_op = 6'd4; ex_funct = 6'd0; ex_br_taken = 1; ex_br_target = 32'h200;
      #1;
      total++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin bad++; $display("FAIL br_flush got=%b%b want=11", flush_if, flush_id); end
      tick();
      total++; if (pc !== 32'h200) begin bad++; $display("FAIL br_over_j got=%h want=%h", pc, 32'h200); end
      exc_req = 1;
      tick();
      total++; if (pc !== 32'h80) begin bad++; $display("FAIL exc_pc got=%h want=%h", pc, 32'h80); end
      total++; if (redirect_cnt !== 16'd4) begin bad++; $display("FAIL exc_cnt got=%0d want=4", redirect_cnt); end
      exc_req = 0; id_valid = 0; ex_valid = 0; ex_br_taken = 0;
   endtask

   task automatic test_stall;
      stall = 1;
      ex_valid = 1; ex_op = 6'd0; ex_funct = 6'd9; ex_rs_val = 32'h1003;
      #1;
      total++; if (flush_if !== 1'b0 || flush_id !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b%b want=00", flush_if, flush_id); end
      tick();
      total++; if (pc !== 32'h80 || pending !== 1'b1) begin bad++; $display("FAIL stall_c1 pc=%h pend=%b want pc=80 pend=1", pc, pending); end
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL addr_err got=%b want=1", addr_err); end
      ex_valid = 0; id_valid = 1; id_op = 6'd2; id_jindex = 26'h2;
      tick();
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_pulse got=%b want=0", addr_err); end
      id_valid = 0;
      tick();
      total++; if (pc !== 32'h80 || pending !== 1'b1) begin bad++; $display("FAIL stall_c3 pc=%h pend=%b want pc=80 pend=1", pc, pending); end
      stall = 0;
      #1;
      total++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin bad++; $display("FAIL unstall_flush got=%b%b want=11", flush_if, flush_id); end
      tick();
      total++; if (pc !== 32'h1000 || pending !== 1'b0) begin bad++; $display("FAIL unstall pc=%h pend=%b want pc=1000 pend=0", pc, pending); end
      total++; if (redirect_cnt !== 16'd5) begin bad++; $display("FAIL unstall_cnt got=%0d want=5", redirect_cnt); end
      tick();
      total++; if (pc !== 32'h1004) begin bad++; $display("FAIL post_seq got=%h want=%h", pc, 32'h1004); end
   endtask

   task automatic test_equal_level;
      stall = 1; ex_valid = 1; ex_op = 6'd4; ex_br_taken = 1; ex_br_target = 32'h500;
      tick();
      ex_br_target = 32'h600;
      tick();
      stall = 0; ex_valid = 0; ex_br_taken = 0; id_valid = 1; id_op = 6'd2; id_jindex = 26'h40;
      tick();
      id_valid = 0;
      total++; if (pc !== 32'h600) begin bad++; $display("FAIL pend_replace got=%h want=%h", pc, 32'h600); end
      stall = 1; ex_valid = 1; ex_br_taken = 1; ex_br_target = 32'h700;
      tick();
      stall = 0; ex_br_target = 32'h800;
      tick();
      ex_valid = 0; ex_br_taken = 0;
      total++; if (pc !== 32'h800) begin bad++; $display("FAIL equal_in_wins got=%h want=%h", pc, 32'h800); end
      total++; if (redirect_cnt !== 16'd7) begin bad++; $display("FAIL eq_cnt got=%0d want=7", redirect_cnt); end
   endtask

   task automatic test_reset_mid_stall;
      stall = 1; ex_valid = 1; ex_op = 6'd4; ex_br_taken = 1; ex_br_target = 32'h3000;
      tick();
      total++; if (pending !== 1'b1) begin bad++; $display("FAIL pre_rst_pend got=%b want=1", pending); end
      ex_valid = 0; ex_br_taken = 0; resetn = 0;
      tick();
      total++; if (pc !== 32'h0 || pending !== 1'b0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst pc=%h pend=%b cnt=%0d want 0/0/0", pc, pending, redirect_cnt); end
      resetn = 1; stall = 0;
      tick();
      total++; if (pc !== 32'h4 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL post_rst pc=%h cnt=%0d want pc=4 cnt=0", pc, redirect_cnt); end
   endtask

   task automatic test_saturate_wrap;
      resetn2 = 1;
      tick();
      total++; if (pc2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h want=%h", pc2, 32'hFFFF_FFFC); end
      tick();
      total++; if (pc2 !== 32'h0) begin bad++; $display("FAIL wrap got=%h want=%h", pc2, 32'h0); end
      exc_req = 1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         total++; if (redirect_cnt2 !== 2'(i > 3 ? 3 : i)) begin bad++; $display("FAIL sat_cnt%0d got=%0d want=%0d", i, redirect_cnt2, (i > 3 ? 3 : i)); end
      end
      exc_req = 0;
      total++; if (pc2 !== 32'h80) begin bad++; $display("FAIL sat_pc got=%h want=%h", pc2, 32'h80); end
   endtask

   initial begin
      test_reset();
      test_idj();
      test_priority();
      test_stall();
      test_equal_level();
      test_reset_mid_stall();
      test_saturate_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
